// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer
//   Sits directly downstream of the sprite ROM.
//   During h-blank it fetches one 8-bit row per sprite slot into a back line buffer.
//   During active video it turns hpos into a registered per-pixel "sprite opaque" flag.
//   Lower slot index wins when sprites overlap.
//   The two line buffers swap on every line_start, so the fetch for line N+1 overlaps the display of line N.
//
// Ports
//   i_clk, i_reset            clock; synchronous active-low reset
//   i_line_start, i_next_y    start of h-blank pulse and the line to fetch
//   i_hpos, i_video_active    current pixel column and visible-region flag
//   i_slot_id/orient/x/y      packed per-slot sprite descriptors (ID 4'hF = empty)
//   o_rom_*, i_rom_data       ROM address phase outputs; registered ROM row back (active-low, bit7 left)
//   o_fetch_busy              high while fetching
//   o_pixel_on, o_pixel_slot  registered opaque flag and winning slot for the previous hpos
//   o_line_overrun            sticky: line_start arrived before the previous fetch finished
//
// Optional feature macro SPRITE_RENDER_COLLIDE_EN adds:
//   i_collision_clear, o_collision_mask   sticky record of slots seen overlapping
//
// state  | meaning
// IDLE   | waiting for line_start
// FETCH  | pipelined ROM fetch, address slot k / capture slot k-1
// DONE   | one-cycle tail after the last capture
module sprite_line_renderer #(
   parameter int NUM_SLOTS  = 4,
   parameter int SCALE_LOG2 = 0,
   parameter int COORD_W    = 10
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic                           i_line_start,
   input  logic [COORD_W-1:0]             i_next_y,
   input  logic [COORD_W-1:0]             i_hpos,
   input  logic                           i_video_active,
   input  logic [4*NUM_SLOTS-1:0]         i_slot_id,
   input  logic [2*NUM_SLOTS-1:0]         i_slot_orient,
   input  logic [COORD_W*NUM_SLOTS-1:0]   i_slot_x,
   input  logic [COORD_W*NUM_SLOTS-1:0]   i_slot_y,
   output logic                           o_rom_read_enable,
   output logic [3:0]                     o_rom_sprite_id,
   output logic [1:0]                     o_rom_orientation,
   output logic [2:0]                     o_rom_line_index,
   input  logic [7:0]                     i_rom_data,
   output logic                           o_fetch_busy,
   output logic                           o_pixel_on,
   output logic [((NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1)-1:0] o_pixel_slot,
   output logic                           o_line_overrun
`ifdef SPRITE_RENDER_COLLIDE_EN
   ,
   input  logic                           i_collision_clear,
   output logic [NUM_SLOTS-1:0]           o_collision_mask
`endif
);

   localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int K_W    = $clog2(NUM_SLOTS + 1);
   localparam int SPAN   = 8 << SCALE_LOG2;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

   state_t               r_state, w_state_nxt;
   logic [K_W-1:0]       r_k;
   logic [COORD_W-1:0]   r_line_y;
   logic                 r_sel;          // index of the front buffer
   logic                 r_hit_d;        // hit of the slot addressed last cycle
   logic [7:0]           r_row [2][NUM_SLOTS];
   logic [NUM_SLOTS-1:0] r_vld [2];

   logic                 w_back;
   logic                 w_addr_phase;
   logic [3:0]           w_cur_id;
   logic [1:0]           w_cur_or;
   logic [COORD_W-1:0]   w_cur_y;
   logic [COORD_W-1:0]   w_dy;
   logic                 w_hit;
   logic [2:0]           w_line_idx;
   logic [NUM_SLOTS-1:0] w_opq;
   logic [SLOT_W-1:0]    w_win;

   assign w_back       = ~r_sel;
   assign w_addr_phase = (r_state == S_FETCH) && (r_k < K_W'(NUM_SLOTS));

   // Descriptor of the slot currently in its address phase.
   always_comb begin
      w_cur_id = '0;
      w_cur_or = '0;
      w_cur_y  = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (r_k == K_W'(s)) begin
            w_cur_id = i_slot_id[4*s +: 4];
            w_cur_or = i_slot_orient[2*s +: 2];
            w_cur_y  = i_slot_y[COORD_W*s +: COORD_W];
         end
      end
   end

   // Modular difference lets sprites straddle the coordinate wrap.
   assign w_dy       = r_line_y - w_cur_y;
   assign w_hit      = (w_dy < COORD_W'(SPAN)) && (w_cur_id != 4'hF);
   assign w_line_idx = 3'(w_dy >> SCALE_LOG2);

   always_ff @(posedge i_clk) begin
      if (!i_reset) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_line_start) w_state_nxt = S_FETCH;
         S_FETCH: if (i_line_start)                   w_state_nxt = S_FETCH;
                  else if (r_k == K_W'(NUM_SLOTS))    w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = i_line_start ? S_FETCH : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_fetch_busy      = (r_state == S_FETCH);
      o_rom_read_enable = w_addr_phase && w_hit;
      o_rom_sprite_id   = w_addr_phase ? w_cur_id   : 4'd0;
      o_rom_orientation = w_addr_phase ? w_cur_or   : 2'd0;
      o_rom_line_index  = w_addr_phase ? w_line_idx : 3'd0;
   end

   // Fetch datapath. A line_start mid-fetch takes priority over the pending capture.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_k            <= '0;
         r_line_y       <= '0;
         r_sel          <= 1'b0;
         r_hit_d        <= 1'b0;
         o_line_overrun <= 1'b0;
         r_vld[0]       <= '0;
         r_vld[1]       <= '0;
         for (int b = 0; b < 2; b++)
            for (int s = 0; s < NUM_SLOTS; s++)
               r_row[b][s] <= 8'hFF;
      end else if (i_line_start) begin
         if (r_state != S_IDLE) o_line_overrun <= 1'b1;
         r_sel        <= ~r_sel;
         r_line_y     <= i_next_y;
         r_k          <= '0;
         r_hit_d      <= 1'b0;
         r_vld[r_sel] <= '0;       // old front becomes the new back
      end else if (r_state == S_FETCH) begin
         r_k     <= r_k + 1'b1;
         r_hit_d <= w_hit;
         for (int s = 0; s < NUM_SLOTS; s++) begin
            if (r_k == K_W'(s + 1)) begin
               r_row[w_back][s]    <= r_hit_d ? i_rom_data : 8'hFF;
               r_vld[w_back][s]    <= r_hit_d;
            end
         end
      end
   end

   // Pixel path from the front buffer.
   always_comb begin
      logic [COORD_W-1:0] v_dx;
      logic [2:0]         v_col;
      logic [7:0]         v_row;
      v_dx  = '0;
      v_col = '0;
      v_row = '0;
      w_opq = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         v_dx     = i_hpos - i_slot_x[COORD_W*s +: COORD_W];
         v_col    = 3'(v_dx >> SCALE_LOG2);
         v_row    = r_row[r_sel][s];
         w_opq[s] = i_video_active && r_vld[r_sel][s] &&
                    (v_dx < COORD_W'(SPAN)) && !v_row[3'd7 - v_col];
      end
   end

   always_comb begin
      w_win = '0;
      for (int s = NUM_SLOTS - 1; s >= 0; s--)
         if (w_opq[s]) w_win = SLOT_W'(s);
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         o_pixel_on   <= 1'b0;
         o_pixel_slot <= '0;
      end else begin
         o_pixel_on   <= |w_opq;
         o_pixel_slot <= w_win;
      end
   end

`ifdef SPRITE_RENDER_COLLIDE_EN
   logic                 w_multi;
   logic [NUM_SLOTS-1:0] w_coll;

   // More than one bit set: clearing the lowest set bit leaves something.
   assign w_multi = |(w_opq & (w_opq - 1'b1));
   assign w_coll  = w_multi ? w_opq : '0;

   always_ff @(posedge i_clk) begin
      if (!i_reset)               o_collision_mask <= '0;
      else if (i_collision_clear) o_collision_mask <= w_coll;
      else                        o_collision_mask <= o_collision_mask | w_coll;
   end
`endif

endmodule

// File: tb/tb_sprite_line_renderer.sv
module tb_sprite_line_renderer;

   logic        clk = 1'b0;
   logic        reset;
   logic        line_start;
   logic [9:0]  next_y;
   logic [9:0]  hpos;
   logic        video_active;
   logic [15:0] slot_id;
   logic [7:0]  slot_orient;
   logic [39:0] slot_x;
   logic [39:0] slot_y;

   logic        rom_re, rom_re_s1;
   logic [3:0]  rom_id, rom_id_s1;
   logic [1:0]  rom_or, rom_or_s1;
   logic [2:0]  rom_li, rom_li_s1;
   logic [7:0]  rom_data = 8'hFF;
   logic [7:0]  rom_data_s1 = 8'hFF;
   logic        busy, busy_s1;
   logic        pix_on, pix_on_s1;
   logic [1:0]  pix_slot, pix_slot_s1;
   logic        overrun, overrun_s1;
`ifdef SPRITE_RENDER_COLLIDE_EN
   logic        coll_clear;
   logic [3:0]  coll_mask, coll_mask_s1;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   sprite_line_renderer #(.NUM_SLOTS(4), .SCALE_LOG2(0), .COORD_W(10)) u_dut (
      .i_clk(clk), .i_reset(reset), .i_line_start(line_start), .i_next_y(next_y),
      .i_hpos(hpos), .i_video_active(video_active), .i_slot_id(slot_id),
      .i_slot_orient(slot_orient), .i_slot_x(slot_x), .i_slot_y(slot_y),
      .o_rom_read_enable(rom_re), .o_rom_sprite_id(rom_id), .o_rom_orientation(rom_or),
      .o_rom_line_index(rom_li), .i_rom_data(rom_data), .o_fetch_busy(busy),
      .o_pixel_on(pix_on), .o_pixel_slot(pix_slot), .o_line_overrun(overrun)
`ifdef SPRITE_RENDER_COLLIDE_EN
      , .i_collision_clear(coll_clear), .o_collision_mask(coll_mask)
`endif
   );

   sprite_line_renderer #(.NUM_SLOTS(4), .SCALE_LOG2(1), .COORD_W(10)) u_dut_s1 (
      .i_clk(clk), .i_reset(reset), .i_line_start(line_start), .i_next_y(next_y),
      .i_hpos(hpos), .i_video_active(video_active), .i_slot_id(slot_id),
      .i_slot_orient(slot_orient), .i_slot_x(slot_x), .i_slot_y(slot_y),
      .o_rom_read_enable(rom_re_s1), .o_rom_sprite_id(rom_id_s1), .o_rom_orientation(rom_or_s1),
      .o_rom_line_index(rom_li_s1), .i_rom_data(rom_data_s1), .o_fetch_busy(busy_s1),
      .o_pixel_on(pix_on_s1), .o_pixel_slot(pix_slot_s1), .o_line_overrun(overrun_s1)
`ifdef SPRITE_RENDER_COLLIDE_EN
      , .i_collision_clear(coll_clear), .o_collision_mask(coll_mask_s1)
`endif
   );

   // ROM: ID 0 is the heart (row 1 = 10011001, other rows clear), any other ID is solid.
   function automatic logic [7:0] rom_row(input logic [3:0] id, input logic [2:0] li);
      if (id == 4'd0) return (li == 3'd1) ? 8'b10011001 : 8'hFF;
      return 8'h00;
   endfunction

   always @(posedge clk) begin
      rom_data    <= rom_re    ? rom_row(rom_id, rom_li)       : 8'hFF;
      rom_data_s1 <= rom_re_s1 ? rom_row(rom_id_s1, rom_li_s1) : 8'hFF;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic set_slot(input int s, input logic [3:0] id, input logic [9:0] x, input logic [9:0] y);
      slot_id[4*s +: 4]    = id;
      slot_orient[2*s +: 2] = 2'd0;
      slot_x[10*s +: 10]   = x;
      slot_y[10*s +: 10]   = y;
   endtask

   // Entered at the negedge of FETCH cycle k=0; leaves one cycle after DONE.
   task automatic run_fetch(input logic [4:0] exp_re, input logic [2:0] exp_li0, input string tag);
      for (int k = 0; k < 5; k++) begin
         chk({tag, "_busy"}, busy, 1);
         chk({tag, "_re"}, rom_re, exp_re[k]);
         if (k == 0) chk({tag, "_li0"}, rom_li, exp_li0);
         @(negedge clk);
      end
      chk({tag, "_done_busy"}, busy, 0);
      chk({tag, "_done_re"}, rom_re, 0);
      @(negedge clk);
   endtask

   task automatic fetch_seq(input logic [9:0] y, input logic [4:0] exp_re,
                            input logic [2:0] exp_li0, input string tag);
      line_start = 1'b1;
      next_y     = y;
      @(negedge clk);
      line_start = 1'b0;
      run_fetch(exp_re, exp_li0, tag);
   endtask

   task automatic pix(input logic [9:0] h, input logic exp_on, input logic [1:0] exp_slot,
                      input string tag);
      hpos = h;
      @(negedge clk);
      chk({tag, "_on"}, pix_on, exp_on);
      chk({tag, "_slot"}, pix_slot, exp_slot);
   endtask

   initial begin
      reset        = 1'b0;
      line_start   = 1'b0;
      next_y       = '0;
      hpos         = '0;
      video_active = 1'b1;
      slot_id      = 16'hFFFF;
      slot_orient  = '0;
      slot_x       = '0;
      slot_y       = '0;
`ifdef SPRITE_RENDER_COLLIDE_EN
      coll_clear   = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_pix_on", pix_on, 0);
      chk("rst_pix_slot", pix_slot, 0);
      chk("rst_busy", busy, 0);
      chk("rst_re", rom_re, 0);
      chk("rst_overrun", overrun, 0);
      reset = 1'b1;
      pix(10'd101, 0, 0, "rst_front_empty");

      // Heart at (100,50), fetch line 51 then swap it to the front.
      set_slot(0, 4'd0, 10'd100, 10'd50);
      fetch_seq(10'd51, 5'b00001, 3'd1, "heart_f51");
      fetch_seq(10'd52, 5'b00001, 3'd2, "heart_f52");
      for (int h = 99; h <= 108; h++)
         pix(10'(h), (h == 101 || h == 102 || h == 105 || h == 106), 0, "heart");
      video_active = 1'b0;
      pix(10'd101, 0, 0, "heart_blank");
      video_active = 1'b1;

      // Priority between overlapping solid sprites.
      set_slot(0, 4'd1, 10'd196, 10'd50);
      set_slot(1, 4'd1, 10'd198, 10'd50);
      fetch_seq(10'd51, 5'b00011, 3'd1, "prio_f51");
      fetch_seq(10'd52, 5'b00011, 3'd2, "prio_f52");
      pix(10'd200, 1, 0, "prio_both");
      pix(10'd197, 1, 0, "prio_s0");
      pix(10'd205, 1, 1, "prio_s1");
      pix(10'd206, 0, 0, "prio_none");
      set_slot(0, 4'hF, 10'd196, 10'd50);
      fetch_seq(10'd51, 5'b00010, 3'd1, "prio_e51");
      fetch_seq(10'd52, 5'b00010, 3'd2, "prio_e52");
      pix(10'd200, 1, 1, "prio_empty0");

      // Vertical wrap and miss.
      set_slot(0, 4'd1, 10'd0, 10'd1020);
      set_slot(1, 4'hF, 10'd0, 10'd0);
      fetch_seq(10'd2, 5'b00001, 3'd6, "wrap");
      set_slot(0, 4'd1, 10'd0, 10'd60);
      fetch_seq(10'd51, 5'b00000, 3'd7, "miss");

      // Overrun: second line_start two cycles after the first.
      set_slot(0, 4'd1, 10'd400, 10'd50);
      set_slot(2, 4'd1, 10'd404, 10'd50);
      set_slot(3, 4'd1, 10'd0, 10'd100);
      chk("ovr_before", overrun, 0);
      line_start = 1'b1;
      next_y     = 10'd51;
      @(negedge clk);
      line_start = 1'b0;
      @(negedge clk);
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      chk("ovr_set", overrun, 1);
      run_fetch(5'b00101, 3'd1, "ovr_restart");
      fetch_seq(10'd52, 5'b00101, 3'd2, "ovr_f52");
      pix(10'd402, 1, 0, "ovr_s0");
      pix(10'd410, 1, 2, "ovr_s2");
      chk("ovr_sticky", overrun, 1);

      // Reset mid-fetch.
      line_start = 1'b1;
      next_y     = 10'd51;
      @(negedge clk);
      line_start = 1'b0;
      @(negedge clk);
      hpos  = 10'd402;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_re", rom_re, 0);
      chk("midrst_pix_on", pix_on, 0);
      chk("midrst_pix_slot", pix_slot, 0);
      chk("midrst_overrun", overrun, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_after_re", rom_re, 0);
      chk("midrst_after_busy", busy, 0);
      pix(10'd402, 0, 0, "midrst_front");

      // Double-size heart on the SCALE_LOG2=1 instance: line 53 -> ROM row 1.
      slot_id = 16'hFFFF;
      set_slot(0, 4'd0, 10'd100, 10'd50);
      fetch_seq(10'd53, 5'b00001, 3'd3, "s1_f53");
      fetch_seq(10'd54, 5'b00001, 3'd4, "s1_f54");
      begin
         logic [9:0] hs [7] = '{10'd101, 10'd102, 10'd105, 10'd106, 10'd110, 10'd113, 10'd114};
         logic [6:0] he = 7'b0110110;   // bit i = expected pixel_on for hs[i]
         for (int i = 0; i < 7; i++) begin
            hpos = hs[i];
            @(negedge clk);
            chk("s1_heart", pix_on_s1, he[i]);
         end
      end

`ifdef SPRITE_RENDER_COLLIDE_EN
      slot_id = 16'hFFFF;
      set_slot(0, 4'd1, 10'd300, 10'd50);
      set_slot(2, 4'd1, 10'd304, 10'd50);
      fetch_seq(10'd51, 5'b00101, 3'd1, "col_f51");
      fetch_seq(10'd52, 5'b00101, 3'd2, "col_f52");
      hpos       = 10'd0;
      coll_clear = 1'b1;
      @(negedge clk);
      coll_clear = 1'b0;
      chk("col_cleared", coll_mask_s1, 4'b0000);
      hpos = 10'd306;
      @(negedge clk);
      chk("col_mask", coll_mask_s1, 4'b0101);
      hpos = 10'd0;
      @(negedge clk);
      chk("col_sticky", coll_mask_s1, 4'b0101);
      coll_clear = 1'b1;
      @(negedge clk);
      coll_clear = 1'b0;
      chk("col_clear", coll_mask_s1, 4'b0000);
      hpos       = 10'd306;
      coll_clear = 1'b1;
      @(negedge clk);
      coll_clear = 1'b0;
      chk("col_clear_same", coll_mask_s1, 4'b0101);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
